// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags and sticky overflow/underflow errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered 1-cycle read.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  input  logic              err_clr,
  output logic [ADDR_W:0]   fifo_cnt,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C   = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C  = (ADDR_W+1)'(AEMPTY_TH);

  // Handshake: wr/rd are requests, not valid/ready pairs. A write is taken when
  // the FIFO is not full or a read leaves this cycle; a read is taken only when
  // not empty. Rejected requests leave all state unchanged and raise a sticky error.

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wa, ra;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == DEPTH_C);
  assign almost_full  = (cnt_q >= AFULL_C);
  assign almost_empty = (cnt_q <= AEMPTY_C);
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wa = wr && (!full || rd);
  assign ra = rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wa) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (ra) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (wa && !ra)      cnt_d = cnt_q + (ADDR_W+1)'(1);
    else if (!wa && ra) cnt_d = cnt_q - (ADDR_W+1)'(1);
    // A new error in the same cycle as err_clr must win.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr && !wa) ovf_d = 1'b1;
    if (rd && !ra) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately unreset; the count guards stale words.
  always_ff @(posedge clk) begin
    if (!rst && wa) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = mem_q[rd_ptr_q];
  assign rd_valid = !empty;
`else
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ra;
      if (ra) data_out_q <= mem_q[rd_ptr_q];
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule
